// File: rtl/drfa_pkg.sv
// Shared definitions for the register spill unit: FSM state encoding,
// transfer-mode encoding, bus geometry and the slot-address helper.
// Optional feature macro: SPILL_SKIP_R0_EN (register 0 excluded from spill/fill).
package drfa_pkg;

  localparam int NUM_REGS   = 8;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int SEL_WIDTH  = 3;

  localparam logic MODE_SAVE    = 1'b0;
  localparam logic MODE_RESTORE = 1'b1;

`ifdef SPILL_SKIP_R0_EN
  // Register 0 is hardwired/owned elsewhere, so the walk starts at r1.
  localparam logic [SEL_WIDTH-1:0] FIRST_IDX = SEL_WIDTH'(1);
`else
  localparam logic [SEL_WIDTH-1:0] FIRST_IDX = '0;
`endif
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE_RD = 3'd1,
    ST_SAVE_WR = 3'd2,
    ST_LOAD_RQ = 3'd3,
    ST_LOAD_WR = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Memory slot for register idx; wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] slot_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [SEL_WIDTH-1:0]  idx
  );
    return base + ADDR_WIDTH'(idx);
  endfunction

endpackage

// File: rtl/register_spill_unit_if.sv
// Command, register-bank and data-memory bus of the register spill unit.
// Modports: master = spill unit (drives out_*, samples in_*),
//           slave  = control unit / register bank / memory side.
interface register_spill_unit_if;
  import drfa_pkg::*;

  // Command handshake
  logic                  in_start;
  logic                  in_mode;
  logic [ADDR_WIDTH-1:0] in_base_addr;
  logic                  out_busy;
  logic                  out_done;
  // Register bank port
  logic                  out_reg_read_en;
  logic                  out_reg_write_en;
  logic [SEL_WIDTH-1:0]  out_reg_selector;
  logic [DATA_WIDTH-1:0] out_reg_data;
  logic [DATA_WIDTH-1:0] in_reg_data;
  // Data memory port
  logic [ADDR_WIDTH-1:0] out_mem_addr;
  logic                  out_mem_read_en;
  logic                  out_mem_write_en;
  logic [DATA_WIDTH-1:0] out_mem_data;
  logic [DATA_WIDTH-1:0] in_mem_data;

  modport master (
    input  in_start, in_mode, in_base_addr, in_reg_data, in_mem_data,
    output out_busy, out_done,
    output out_reg_read_en, out_reg_write_en, out_reg_selector, out_reg_data,
    output out_mem_addr, out_mem_read_en, out_mem_write_en, out_mem_data
  );

  modport slave (
    output in_start, in_mode, in_base_addr, in_reg_data, in_mem_data,
    input  out_busy, out_done,
    input  out_reg_read_en, out_reg_write_en, out_reg_selector, out_reg_data,
    input  out_mem_addr, out_mem_read_en, out_mem_write_en, out_mem_data
  );

endinterface

// File: rtl/register_spill_unit.sv
// Register spill unit: saves all general registers to data memory or restores
// them from it as one start/done command (2 cycles per register, done pulse after).
// Ports: clk, rst (sync, active-high), bus (register_spill_unit_if.master).
// Optional macro: SPILL_SKIP_R0_EN skips register 0 (7 registers, 14 transfer cycles).
// in_start is only honoured in IDLE; requests while busy or done are dropped.
module register_spill_unit
  import drfa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  register_spill_unit_if.master bus
);

  state_e                state_q;
  logic [SEL_WIDTH-1:0]  idx_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  reg_rd_q;
  logic                  reg_wr_q;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] hold_q;   // register value captured in SAVE_RD

  logic [SEL_WIDTH-1:0]  idx_nxt;
  logic                  last_idx;

  assign idx_nxt  = idx_q + SEL_WIDTH'(1);
  assign last_idx = (idx_q == LAST_IDX);

  // Single FSM; every strobe is registered alongside the state it belongs to,
  // so each strobe is high exactly in the cycle its state is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      base_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reg_rd_q <= 1'b0;
      reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      hold_q   <= '0;
    end else begin
      reg_rd_q <= 1'b0;
      reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_start) begin
            base_q <= bus.in_base_addr;
            idx_q  <= FIRST_IDX;
            busy_q <= 1'b1;
            if (bus.in_mode == MODE_SAVE) begin
              state_q  <= ST_SAVE_RD;
              reg_rd_q <= 1'b1;
              sel_q    <= FIRST_IDX;
            end else begin
              state_q  <= ST_LOAD_RQ;
              mem_rd_q <= 1'b1;
              addr_q   <= slot_addr(bus.in_base_addr, FIRST_IDX);
            end
          end
        end
        ST_SAVE_RD: begin
          // in_reg_data is combinational from the selector we drove this cycle.
          hold_q   <= bus.in_reg_data;
          mem_wr_q <= 1'b1;
          addr_q   <= slot_addr(base_q, idx_q);
          state_q  <= ST_SAVE_WR;
        end
        ST_SAVE_WR: begin
          if (last_idx) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q    <= idx_nxt;
            reg_rd_q <= 1'b1;
            sel_q    <= idx_nxt;
            state_q  <= ST_SAVE_RD;
          end
        end
        ST_LOAD_RQ: begin
          reg_wr_q <= 1'b1;
          sel_q    <= idx_q;
          state_q  <= ST_LOAD_WR;
        end
        ST_LOAD_WR: begin
          if (last_idx) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q    <= idx_nxt;
            mem_rd_q <= 1'b1;
            addr_q   <= slot_addr(base_q, idx_nxt);
            state_q  <= ST_LOAD_RQ;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_busy         = busy_q;
  assign bus.out_done         = done_q;
  assign bus.out_reg_read_en  = reg_rd_q;
  assign bus.out_reg_write_en = reg_wr_q;
  assign bus.out_reg_selector = sel_q;
  assign bus.out_mem_addr     = addr_q;
  assign bus.out_mem_read_en  = mem_rd_q;
  assign bus.out_mem_write_en = mem_wr_q;
  assign bus.out_mem_data     = hold_q;
  // Memory read data only arrives in LOAD_WR, the same cycle the bank writes it,
  // so it is forwarded straight through rather than registered.
  assign bus.out_reg_data     = (state_q == ST_LOAD_WR) ? bus.in_mem_data : '0;

endmodule

// File: tb/tb_register_spill_unit.sv
module tb_register_spill_unit;
  import drfa_pkg::*;

`ifdef SPILL_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_spill_unit_if bus();

  register_spill_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment: register bank (combinational read) and memory (1-cycle read).
  logic [7:0] regs [8];
  logic [7:0] mem  [256];
  logic [7:0] mem_rd_q;
  logic [7:0] seed_regs [8];
  logic [7:0] seed_mem  [256];
  logic       load_req;

  assign bus.in_reg_data = regs[bus.out_reg_selector];
  assign bus.in_mem_data = mem_rd_q;

  always @(posedge clk) begin
    if (load_req) begin
      regs     <= seed_regs;
      mem      <= seed_mem;
      mem_rd_q <= 8'h00;
    end else begin
      if (bus.out_mem_write_en) mem[bus.out_mem_addr] <= bus.out_mem_data;
      if (bus.out_mem_read_en)  mem_rd_q <= mem[bus.out_mem_addr];
      if (bus.out_reg_write_en) regs[bus.out_reg_selector] <= bus.out_reg_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_state();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Runs one command and checks it against a behavioural model: which slots or
  // registers end up holding what, cycle-level busy/done timing, strobe counts.
  task automatic run_cmd(input logic mode, input logic [7:0] base, input bit extra,
                         input int rst_at, input string nm);
    int count, n_xfer, n_comp, exp_done, mism;
    int busy_bad, done_cnt, done_cyc, multi, late, mwr, rwr, seq_bad, last_rd_cyc, ns;
    logic exp_busy;
    logic [7:0] last_rd_addr, a;
    logic [7:0] exp_mem  [256];
    logic [7:0] exp_regs [8];
    logic [7:0] xq [$];

    count  = NUM_REGS - FIRST;
    n_xfer = 2 * count;
    // Transfer k is committed by its write strobe in relative cycle 2k+2.
    n_comp = 0;
    for (int k = 0; k < count; k++)
      if (rst_at == 0 || 2 * k + 2 <= rst_at) n_comp++;
    exp_done = (rst_at > 0 && rst_at <= n_xfer) ? 0 : 1;

    exp_mem  = mem;
    exp_regs = regs;
    for (int k = 0; k < n_comp; k++) begin
      a = base + 8'(FIRST + k);
      if (mode == MODE_SAVE) exp_mem[a] = regs[FIRST + k];
      else                   exp_regs[FIRST + k] = mem[a];
    end

    busy_bad = 0; done_cnt = 0; done_cyc = -1; multi = 0; late = 0;
    mwr = 0; rwr = 0; seq_bad = 0; last_rd_cyc = -10; last_rd_addr = 8'h00;

    @(negedge clk);
    bus.in_start     = 1'b1;
    bus.in_mode      = mode;
    bus.in_base_addr = base;
    @(posedge clk);  // edge 0
    for (int c = 1; c <= n_xfer + 6; c++) begin
      @(negedge clk);
      ns = int'(bus.out_reg_read_en) + int'(bus.out_reg_write_en)
         + int'(bus.out_mem_read_en) + int'(bus.out_mem_write_en);
      if (ns > 1) multi++;
      exp_busy = (rst_at > 0 && c > rst_at) ? 1'b0 : (c <= n_xfer);
      if (bus.out_busy !== exp_busy) busy_bad++;
      if (bus.out_done) begin done_cnt++; done_cyc = c; end
      if (rst_at > 0 && c > rst_at && (ns != 0 || bus.out_done)) late++;
      if (bus.out_mem_write_en) begin mwr++; xq.push_back(bus.out_mem_addr); end
      if (bus.out_mem_read_en) begin
        xq.push_back(bus.out_mem_addr);
        last_rd_cyc  = c;
        last_rd_addr = bus.out_mem_addr;
      end
      if (bus.out_reg_write_en) begin
        rwr++;
        a = last_rd_addr - base;
        if (last_rd_cyc != c - 1 || a != {5'b0, bus.out_reg_selector}) seq_bad++;
      end
      bus.in_start = extra && (c == 5 || c == n_xfer + 1);
      rst = (rst_at > 0 && c == rst_at);
    end
    bus.in_start = 1'b0;
    rst = 1'b0;

    check_eq({nm, "_busy"}, busy_bad, 0);
    check_eq({nm, "_done_cnt"}, done_cnt, exp_done);
    if (exp_done == 1) check_eq({nm, "_done_cyc"}, done_cyc, n_xfer + 1);
    check_eq({nm, "_one_strobe"}, multi, 0);
    check_eq({nm, "_after_rst"}, late, 0);
    check_eq({nm, "_mem_wr_cnt"}, mwr, (mode == MODE_SAVE) ? n_comp : 0);
    check_eq({nm, "_reg_wr_cnt"}, rwr, (mode == MODE_RESTORE) ? n_comp : 0);
    check_eq({nm, "_rd_then_wr"}, seq_bad, 0);
    for (int k = 0; k < xq.size(); k++)
      check_eq($sformatf("%s_addr%0d", nm, k), int'(xq[k]), int'(8'(base + 8'(FIRST + k))));
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("%s_r%0d", nm, i), int'(regs[i]), int'(exp_regs[i]));
    mism = 0;
    for (int j = 0; j < 256; j++) if (mem[j] !== exp_mem[j]) mism++;
    check_eq({nm, "_mem_mism"}, mism, 0);
  endtask

  initial begin
    rst = 1'b1;
    load_req = 1'b0;
    bus.in_start = 1'b0;
    bus.in_mode = 1'b0;
    bus.in_base_addr = 8'h00;
    for (int i = 0; i < 8; i++)   seed_regs[i] = 8'($urandom);
    for (int j = 0; j < 256; j++) seed_mem[j]  = 8'($urandom);
    load_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",  int'(bus.out_busy), 0);
    check_eq("rst_done",  int'(bus.out_done), 0);
    check_eq("rst_strb",  int'({bus.out_reg_read_en, bus.out_reg_write_en,
                                bus.out_mem_read_en, bus.out_mem_write_en}), 0);
    check_eq("rst_sel",   int'(bus.out_reg_selector), 0);
    check_eq("rst_addr",  int'(bus.out_mem_addr), 0);
    check_eq("rst_rdata", int'(bus.out_reg_data), 0);
    check_eq("rst_mdata", int'(bus.out_mem_data), 0);
    rst = 1'b0;

    // Save r0..r7 = 0x10..0x17 to base 0x40
    seed_mem = mem;
    for (int i = 0; i < 8; i++) seed_regs[i] = 8'h10 + 8'(i);
    load_state();
    run_cmd(MODE_SAVE, 8'h40, 1'b0, 0, "save40");
    check_eq("save40_m47", int'(mem[8'h47]), 8'h17);

    // Restore from base 0x80 = 0xA0..0xA7
    seed_regs = regs;
    seed_mem  = mem;
    for (int i = 0; i < 8; i++) seed_mem[8'h80 + i] = 8'hA0 + 8'(i);
    load_state();
    run_cmd(MODE_RESTORE, 8'h80, 1'b0, 0, "rest80");
    check_eq("rest80_r7", int'(regs[7]), 8'hA7);

    // Address wrap
    run_cmd(MODE_SAVE, 8'hFC, 1'b0, 0, "wrapFC");
    check_eq("wrapFC_m03", int'(mem[8'h03]), int'(regs[7]));

    // Extra start pulses mid-transfer and during DONE are dropped
    for (int i = 0; i < 8; i++) seed_regs[i] = 8'($urandom);
    seed_mem = mem;
    load_state();
    run_cmd(MODE_SAVE, 8'($urandom), 1'b1, 0, "ignore");

    // Reset in cycle 7 of a restore
    for (int j = 0; j < 256; j++) seed_mem[j] = 8'($urandom);
    seed_regs = regs;
    load_state();
    run_cmd(MODE_RESTORE, 8'($urandom), 1'b0, 7, "rst7");

    // Randomized commands
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) seed_regs[i] = 8'($urandom);
      for (int j = 0; j < 256; j++) seed_mem[j] = 8'($urandom);
      load_state();
      run_cmd(1'($urandom), 8'($urandom), 1'($urandom), 0, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
